// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths,
// access-owner encoding, arbitration FSM states and a saturating counter helper.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 10;
    localparam int MEM_ARB_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_FAIR = 2'd2
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_rdpipe.sv
// Read-return steering for the memory port arbiter. Tracks which requester
// owns each issued access for two cycles so that synchronous-RAM read data is
// presented to the correct requester with a one-cycle valid strobe. Each
// requester's rdata holds the last word it received between strobes.
module mem_arb_rdpipe
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = MEM_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  owner_e            issue_own_i,
    input  logic              issue_rd_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    owner_e            s1_own_q;
    logic              s1_rd_q;
    logic              cpu_rvalid_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_hold_q;
    logic [DATA_W-1:0] dbg_hold_q;

    // Owner/read-flag pipeline and per-requester data holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_own_q     <= OWN_NONE;
            s1_rd_q      <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_hold_q   <= {DATA_W{1'b0}};
            dbg_hold_q   <= {DATA_W{1'b0}};
        end else begin
            s1_own_q     <= issue_own_i;
            s1_rd_q      <= issue_rd_i;
            cpu_rvalid_q <= s1_rd_q && (s1_own_q == OWN_CPU);
            dbg_rvalid_q <= s1_rd_q && (s1_own_q == OWN_DBG);
            if (cpu_rvalid_q) begin
                cpu_hold_q <= mem_rdata_i;
            end
            if (dbg_rvalid_q) begin
                dbg_hold_q <= mem_rdata_i;
            end
        end
    end

    // RAM data passes straight through in the valid cycle, held copy otherwise.
    always_comb begin
        if (cpu_rvalid_q) begin
            cpu_rdata_o = mem_rdata_i;
        end else begin
            cpu_rdata_o = cpu_hold_q;
        end
        if (dbg_rvalid_q) begin
            dbg_rdata_o = mem_rdata_i;
        end else begin
            dbg_rdata_o = dbg_hold_q;
        end
    end

    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dbg_rvalid_o = dbg_rvalid_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port (CPU control unit and
// debug/loader master). One access per cycle, registered issue to the RAM,
// CPU priority with natural alternation, and a bounded locked burst for the
// debug master that is forcibly broken after MAX_LOCK grants.
// Optional grant statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = MEM_ARB_ADDR_W,
    parameter int DATA_W   = MEM_ARB_DATA_W,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_lock_lost,
`ifdef MEM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       cpu_gnt_cnt,
    output logic [15:0]       dbg_gnt_cnt,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] LOCK_MAX_C = 8'(MAX_LOCK);

    state_e            state_q;
    state_e            state_d;
    logic [7:0]        lock_cnt_q;
    logic [7:0]        lock_cnt_d;
    logic              dbg_low_q;
    logic              cpu_gnt_q;
    logic              dbg_gnt_q;
    logic              lost_q;
    logic              lost_d;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    owner_e            grant_s;
    logic              cpu_elig_s;
    logic              dbg_elig_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              issue_rd_s;

    // A requester that is seeing its grant this cycle may not be issued again.
    assign cpu_elig_s = cpu_req && !cpu_gnt_q;
    assign dbg_elig_s = dbg_req && !dbg_gnt_q;

    // Arbitration decision and next FSM state / lock bookkeeping.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        lost_d     = 1'b0;
        grant_s    = OWN_NONE;
        case (state_q)
            ST_IDLE: begin
                if (cpu_elig_s) begin
                    grant_s = OWN_CPU;
                end else if (dbg_elig_s) begin
                    grant_s = OWN_DBG;
                    if (dbg_lock) begin
                        state_d    = ST_LOCK;
                        lock_cnt_d = 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (lock_cnt_q == LOCK_MAX_C) begin
                    // Burst exhausted: break the lock and let the CPU in first.
                    lost_d     = 1'b1;
                    state_d    = ST_FAIR;
                    lock_cnt_d = 8'd0;
                end else if (!dbg_req) begin
                    if (dbg_low_q) begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end else if (!dbg_lock) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = 8'd0;
                end else if (dbg_elig_s) begin
                    grant_s    = OWN_DBG;
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            ST_FAIR: begin
                if (!cpu_req) begin
                    state_d = ST_IDLE;
                end else if (cpu_elig_s) begin
                    grant_s = OWN_CPU;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAIR;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    // Select the winning request's write enable, address and data.
    always_comb begin
        case (grant_s)
            OWN_CPU: begin
                sel_we_s    = cpu_we;
                sel_addr_s  = cpu_addr;
                sel_wdata_s = cpu_wdata;
            end
            OWN_DBG: begin
                sel_we_s    = dbg_we;
                sel_addr_s  = dbg_addr;
                sel_wdata_s = dbg_wdata;
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = {ADDR_W{1'b0}};
                sel_wdata_s = {DATA_W{1'b0}};
            end
        endcase
        if (grant_s != OWN_NONE) begin
            issue_rd_s = !sel_we_s;
        end else begin
            issue_rd_s = 1'b0;
        end
    end

    // FSM state, grant pulses and registered RAM command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_cnt_q  <= 8'd0;
            dbg_low_q   <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            lost_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            dbg_low_q   <= !dbg_req;
            cpu_gnt_q   <= (grant_s == OWN_CPU);
            dbg_gnt_q   <= (grant_s == OWN_DBG);
            lost_q      <= lost_d;
            mem_we_q    <= sel_we_s;
            mem_addr_q  <= sel_addr_s;
            mem_wdata_q <= sel_wdata_s;
        end
    end

    mem_arb_rdpipe #(
        .DATA_W (DATA_W)
    ) u_rdpipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_own_i  (grant_s),
        .issue_rd_i   (issue_rd_s),
        .mem_rdata_i  (mem_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .dbg_rvalid_o (dbg_rvalid),
        .dbg_rdata_o  (dbg_rdata)
    );

`ifdef MEM_ARB_STATS_EN
    logic [15:0] cpu_cnt_q;
    logic [15:0] dbg_cnt_q;

    // Saturating grant counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cnt_q <= 16'd0;
            dbg_cnt_q <= 16'd0;
        end else if (stats_clr) begin
            cpu_cnt_q <= 16'd0;
            dbg_cnt_q <= 16'd0;
        end else begin
            if (grant_s == OWN_CPU) begin
                cpu_cnt_q <= sat_inc16(cpu_cnt_q);
            end
            if (grant_s == OWN_DBG) begin
                dbg_cnt_q <= sat_inc16(dbg_cnt_q);
            end
        end
    end

    assign cpu_gnt_cnt = cpu_cnt_q;
    assign dbg_gnt_cnt = dbg_cnt_q;
`endif

    assign cpu_gnt       = cpu_gnt_q;
    assign dbg_gnt       = dbg_gnt_q;
    assign dbg_lock_lost = lost_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter with a 1K x 8 read-first synchronous RAM.
// A per-cycle reference model predicts grants, RAM commands and read returns;
// directed sequences add hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int ML = 4;
    localparam int NC = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt, dbg_rvalid, dbg_lock_lost;
    logic [DW-1:0] dbg_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic          stats_clr = 1'b0;
    logic [15:0]   cpu_gnt_cnt, dbg_gnt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock_lost(dbg_lock_lost),
`ifdef MEM_ARB_STATS_EN
        .stats_clr(stats_clr), .cpu_gnt_cnt(cpu_gnt_cnt), .dbg_gnt_cnt(dbg_gnt_cnt),
`endif
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Synchronous read-first RAM.
    logic [7:0] ram [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h155] = 8'hA5;
        mem_rdata <= 8'h00;
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
    end

    // Reference model: expected outputs per cycle index.
    bit            e_cg [NC];
    bit            e_dg [NC];
    bit            e_we [NC];
    bit            e_crv [NC];
    bit            e_drv [NC];
    bit            e_lost [NC];
    logic [AW-1:0] e_addr [NC];
    logic [DW-1:0] e_wd [NC];
    logic [DW-1:0] e_crd [NC];
    logic [DW-1:0] e_drd [NC];

    initial begin : model
        int         cyc;
        int         mode;   // 0 shared, 1 debug burst, 2 CPU catch-up
        int         burst;
        int         who;
        bit         dbg_quiet;
        bit         c_ok, d_ok, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] hc, hd;
        logic [7:0] m_mem [0:1023];
        logic [15:0] s_c, s_d;
        cyc = 0; mode = 0; burst = 0; dbg_quiet = 1'b0; hc = '0; hd = '0;
        s_c = 16'd0; s_d = 16'd0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
        m_mem[10'h155] = 8'hA5;
        forever begin
            @(negedge clk);
            if (cyc < NC - 4) begin
                if (!rst_n) begin
                    chk("rst_ctl", 32'({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, dbg_lock_lost, mem_we}), 32'h0);
                    chk("rst_data", 32'({cpu_rdata, dbg_rdata, mem_wdata}), 32'h0);
                    chk("rst_addr", 32'(mem_addr), 32'h0);
                    for (int j = 1; j <= 2; j++) begin
                        e_cg[cyc+j] = 1'b0; e_dg[cyc+j] = 1'b0; e_we[cyc+j] = 1'b0;
                        e_crv[cyc+j] = 1'b0; e_drv[cyc+j] = 1'b0; e_lost[cyc+j] = 1'b0;
                    end
                    mode = 0; burst = 0; dbg_quiet = 1'b0; hc = '0; hd = '0;
                    s_c = 16'd0; s_d = 16'd0;
`ifdef MEM_ARB_STATS_EN
                    chk("rst_stats", {cpu_gnt_cnt, dbg_gnt_cnt}, 32'h0);
`endif
                end else begin
                    chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg[cyc]));
                    chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dg[cyc]));
                    chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
                    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv[cyc]));
                    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_drv[cyc]));
                    chk("dbg_lock_lost", 32'(dbg_lock_lost), 32'(e_lost[cyc]));
                    if (e_crv[cyc]) hc = e_crd[cyc];
                    if (e_drv[cyc]) hd = e_drd[cyc];
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(hc));
                    chk("dbg_rdata", 32'(dbg_rdata), 32'(hd));
                    if (e_cg[cyc] || e_dg[cyc]) begin
                        chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
                        if (e_we[cyc]) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd[cyc]));
                    end
`ifdef MEM_ARB_STATS_EN
                    chk("cpu_gnt_cnt", 32'(cpu_gnt_cnt), 32'(s_c));
                    chk("dbg_gnt_cnt", 32'(dbg_gnt_cnt), 32'(s_d));
`endif
                    // Who may be served this cycle, and who is.
                    c_ok = cpu_req && !e_cg[cyc];
                    d_ok = dbg_req && !e_dg[cyc];
                    who = 0;
                    if (mode == 1) begin
                        if (burst == ML) begin
                            e_lost[cyc+1] = 1'b1; mode = 2; burst = 0;
                        end else if (!dbg_req) begin
                            if (dbg_quiet) begin mode = 0; burst = 0; end
                        end else if (!dbg_lock) begin
                            mode = 0; burst = 0;
                        end else if (d_ok) begin
                            who = 2; burst++;
                        end
                    end else if (mode == 2) begin
                        if (!cpu_req) mode = 0;
                        else if (c_ok) begin who = 1; mode = 0; end
                    end else begin
                        if (c_ok) who = 1;
                        else if (d_ok) begin
                            who = 2;
                            if (dbg_lock) begin mode = 1; burst = 1; end
                        end
                    end
                    dbg_quiet = !dbg_req;
                    if (who != 0) begin
                        w = (who == 1) ? cpu_we : dbg_we;
                        a = (who == 1) ? cpu_addr : dbg_addr;
                        d = (who == 1) ? cpu_wdata : dbg_wdata;
                        if (who == 1) e_cg[cyc+1] = 1'b1; else e_dg[cyc+1] = 1'b1;
                        e_we[cyc+1] = w; e_addr[cyc+1] = a; e_wd[cyc+1] = d;
                        if (w) m_mem[a] = d;
                        else if (who == 1) begin e_crv[cyc+2] = 1'b1; e_crd[cyc+2] = m_mem[a]; end
                        else begin e_drv[cyc+2] = 1'b1; e_drd[cyc+2] = m_mem[a]; end
                    end
`ifdef MEM_ARB_STATS_EN
                    if (stats_clr) begin s_c = 16'd0; s_d = 16'd0; end
                    else begin
                        if (who == 1 && s_c != 16'hFFFF) s_c = s_c + 16'd1;
                        if (who == 2 && s_d != 16'hFFFF) s_d = s_d + 16'd1;
                    end
`endif
                end
            end
            cyc++;
        end
    end

    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd;

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit seen = 1'b0;
        @(posedge clk); #1;
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge clk);
            if (cpu_gnt) begin seen = 1'b1; g_we = mem_we; g_addr = mem_addr; g_wd = mem_wdata; end
        end
        chk("cpu_gnt_seen", 32'(seen), 32'h1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic dbg_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit seen = 1'b0;
        @(posedge clk); #1;
        dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_lock = 1'b0; dbg_req = 1'b1;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge clk);
            if (dbg_gnt) begin seen = 1'b1; g_we = mem_we; g_addr = mem_addr; g_wd = mem_wdata; end
        end
        chk("dbg_gnt_seen", 32'(seen), 32'h1);
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    task automatic wait_crv(output logic [DW-1:0] d);
        bit seen = 1'b0;
        d = '0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (cpu_rvalid) begin seen = 1'b1; d = cpu_rdata; end
        end
        chk("cpu_rvalid_seen", 32'(seen), 32'h1);
    endtask

    int pat  [11];
    int lost [11];
    int exp_alt  [8]  = '{0, 1, 2, 1, 2, 1, 2, 1};
    int exp_lock [11] = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 1, 2};

    initial begin : main
        logic [DW-1:0] rd;
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

`ifdef MEM_ARB_STATS_EN
        // Grant statistics: 3 CPU + 2 DBG, then clear.
        repeat (3) cpu_access(1'b0, 10'h010, 8'h00);
        repeat (2) dbg_access(1'b0, 10'h011, 8'h00);
        @(negedge clk);
        chk("stats_cpu_3", 32'(cpu_gnt_cnt), 32'd3);
        chk("stats_dbg_2", 32'(dbg_gnt_cnt), 32'd2);
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_clr", {cpu_gnt_cnt, dbg_gnt_cnt}, 32'h0);
`endif

        // T1: preloaded read, exact latency.
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 10'h155; cpu_req = 1'b1;
        @(negedge clk);
        chk("t1_c0_gnt", 32'(cpu_gnt), 32'h0);
        @(negedge clk);
        chk("t1_c1_gnt", 32'(cpu_gnt), 32'h1);
        chk("t1_c1_addr", 32'(mem_addr), 32'h155);
        chk("t1_c1_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        chk("t1_c2_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("t1_c2_rdata", 32'(cpu_rdata), 32'hA5);

        // T2: debug write then CPU read-back.
        dbg_access(1'b1, 10'h3FF, 8'h5A);
        chk("t2_we", 32'(g_we), 32'h1);
        chk("t2_addr", 32'(g_addr), 32'h3FF);
        chk("t2_wdata", 32'(g_wd), 32'h5A);
        cpu_access(1'b0, 10'h3FF, 8'h00);
        wait_crv(rd);
        chk("t2_rdata", 32'(rd), 32'h5A);

        // T3: both held, no lock -> CPU, DBG alternation.
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 10'h001; dbg_we = 1'b0; dbg_addr = 10'h002; dbg_lock = 1'b0;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_alt", 32'((cpu_gnt ? 1 : 0) + (dbg_gnt ? 2 : 0)), 32'(exp_alt[k]));
        end
        @(posedge clk); #1 cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (4) @(posedge clk);

        // T4: locked burst broken after ML grants, CPU served next.
        #1;
        dbg_we = 1'b0; dbg_addr = 10'h155; dbg_lock = 1'b1; dbg_req = 1'b1;
        @(negedge clk);
        pat[0] = (cpu_gnt ? 1 : 0) + (dbg_gnt ? 2 : 0); lost[0] = dbg_lock_lost ? 1 : 0;
        @(posedge clk); #1 cpu_we = 1'b0; cpu_addr = 10'h3FF; cpu_req = 1'b1;
        for (int k = 1; k < 11; k++) begin
            @(negedge clk);
            pat[k] = (cpu_gnt ? 1 : 0) + (dbg_gnt ? 2 : 0); lost[k] = dbg_lock_lost ? 1 : 0;
        end
        for (int k = 0; k < 11; k++) begin
            chk("t4_grant", 32'(pat[k]), 32'(exp_lock[k]));
            chk("t4_lost", 32'(lost[k]), (k == 8) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1 cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        repeat (5) @(posedge clk);

        // Lock released by dropping dbg_lock before the limit.
        #1 dbg_addr = 10'h200; dbg_we = 1'b1; dbg_wdata = 8'h33; dbg_lock = 1'b1; dbg_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 dbg_lock = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h200;
        repeat (4) @(posedge clk);
        #1 cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (4) @(posedge clk);

        // Mixed traffic pattern checked by the model.
        for (int k = 0; k < 60; k++) begin
            #1;
            cpu_req = (k % 3) != 2;       dbg_req = (k % 5) < 3;
            dbg_lock = (k % 11) < 4;
            cpu_we = (k % 2) == 1;        dbg_we = (k % 4) >= 2;
            cpu_addr = 10'(k * 7);        dbg_addr = 10'(k * 7 + 3);
            cpu_wdata = 8'(k * 13);       dbg_wdata = 8'(k * 29 + 1);
            @(posedge clk);
        end
        #1 cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        repeat (6) @(posedge clk);

        // T5: reset between debug grant and its read return.
        #1 dbg_we = 1'b0; dbg_addr = 10'h155; dbg_lock = 1'b0; dbg_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (dbg_gnt) seen = 1'b1;
        end
        chk("t5_gnt_seen", 32'(seen), 32'h1);
        #1 rst_n = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        chk("t5_rvalid_rst", 32'(dbg_rvalid), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_rvalid", 32'(dbg_rvalid), 32'h0);
        end
        cpu_access(1'b0, 10'h155, 8'h00);
        wait_crv(rd);
        chk("t5_after_rst", 32'(rd), 32'hA5);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #80000;
        $display("FAIL watchdog: run exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 1K x 8 data-memory write/read port between two requesters: the CPU control unit and a debug/loader master (program load, memory dump). It issues at most one access per clk cycle, routes synchronous-RAM read data back to the owning requester with a valid strobe, and supports a bounded locked burst for the debug master. It sits between ControlUnit/debug logic and the Memory instance and runs entirely on clk.

Parameters:
ADDR_W, 10, memory address width.
DATA_W, 8, memory data width.
MAX_LOCK, 8, maximum debug grants per locked burst before the lock is forcibly broken (range 1..255).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request; held with addr/we/wdata until cpu_gnt seen
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse: CPU access issued to RAM this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same rules as CPU
dbg_lock  in  1  request a locked burst; sampled together with dbg_req
dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug equivalents
dbg_lock_lost  out  1  one-cycle pulse when the lock is forcibly broken
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after address

Behaviour:
- Reset: all outputs 0; FSM=IDLE; lock_cnt=0; in-flight reads discarded.
- Eligibility in cycle N: req high and that requester's gnt not high in cycle N. This prevents double-issue while the requester reacts to gnt.
- Decision in cycle N is registered. In cycle N+1: gnt pulse, and mem_we/mem_addr/mem_wdata driven from the captured request. mem_we is 0 in any cycle with no grant.
- Reads: rvalid pulses at N+2, and rdata equals mem_rdata captured into a register at N+2. rdata holds its last value otherwise. Writes produce no rvalid.
- Throughput: one access per cycle total; each requester gets at most one access every 2 cycles.
- FSM states: IDLE, LOCK, FAIR.
  - IDLE: CPU has priority over DBG. A DBG grant with dbg_lock=1 moves to LOCK, lock_cnt=1.
  - LOCK: CPU is ineligible. Each DBG grant increments lock_cnt.
    - dbg_lock low when sampled -> IDLE.
    - dbg_req low for 2 consecutive cycles -> IDLE.
    - lock_cnt==MAX_LOCK after a grant -> dbg_lock_lost pulse next cycle, go to FAIR.
  - FAIR: CPU has strict priority, and DBG is ineligible while cpu_req is high. Returns to IDLE after a CPU grant or when cpu_req is low.
- A CPU read and a DBG write to the same address are serialized in grant order; no forwarding is done. The RAM's read-first/write-first behaviour applies.
- Simultaneous eligible requests in IDLE: CPU wins. The CPU is then ineligible next cycle, so DBG wins that cycle, giving natural alternation.
- Reset mid-operation: a pending gnt or rvalid never appears after rst_n deasserts.

Optional Feature:
MEM_ARB_STATS_EN:
- When defined: adds outputs cpu_gnt_cnt[15:0] and dbg_gnt_cnt[15:0], plus input stats_clr.
  - Each counter increments on its gnt and saturates at 0xFFFF.
  - stats_clr clears both counters synchronously and has priority over increment.
  - Both counters reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - ADDR_W/DATA_W defaults;
  - owner encoding OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DBG=2'd2;
  - FSM state encoding ST_IDLE/ST_LOCK/ST_FAIR.
- One sub-module, mem_arb_rdpipe: a 2-stage owner/read-flag pipeline producing rvalid/rdata steering. It is instantiated once, and the top holds the FSM and eligibility logic.

Test Plan:
- Preload RAM[0x155]=0xA5. cpu_req read 0x155 at cycle 0 -> cpu_gnt at 1 with mem_addr=0x155, mem_we=0; cpu_rvalid at 2 with cpu_rdata=0xA5.
- dbg write 0x3FF<=0x5A, then cpu read 0x3FF -> mem_we=1 one cycle with mem_wdata=0x5A; cpu_rdata=0x5A.
- cpu_req and dbg_req both held continuously, no lock -> grants alternate CPU,DBG,CPU,DBG starting with CPU; never two gnts in the same cycle.
- MAX_LOCK=4, dbg_lock=1 and dbg_req held, cpu_req high -> 4 DBG grants with no CPU grant; dbg_lock_lost pulses; next grant is CPU (FAIR), then IDLE.
- dbg read issued, rst_n pulsed low between gnt and rvalid -> no dbg_rvalid; all outputs 0; FSM IDLE.
- With MEM_ARB_STATS_EN: 3 CPU and 2 DBG accesses -> cpu_gnt_cnt=3, dbg_gnt_cnt=2; stats_clr -> both 0.
